// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller.
// Captures rising edges on the device request lines into pending bits, applies
// a per-source mask and a global enable, and presents the lowest-index eligible
// source to the CPU with a req/ack handshake. After the ack, no further request
// is raised until software writes end-of-interrupt to the CUR register.
module irq_ctrl #(
    parameter logic [15:0] BASE  = 16'h7F20,
    parameter int          N_SRC = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      addr,
    input  logic             we,
    input  logic [31:0]      wd,
    output logic [31:0]      rd,
    input  logic [N_SRC-1:0] irq_in,
    output logic             int_req,
    output logic [2:0]       int_id,
    input  logic             int_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } state_t;

    localparam logic [3:0] OFF_CTRL = 4'h0;
    localparam logic [3:0] OFF_MASK = 4'h4;
    localparam logic [3:0] OFF_PEND = 4'h8;
    localparam logic [3:0] OFF_CUR  = 4'hC;

    state_t             state;
    state_t             state_nxt;
    logic               ctrl_ge;
    logic [N_SRC-1:0]   mask;
    logic [N_SRC-1:0]   pending;
    logic [N_SRC-1:0]   irq_prev;
    logic               int_req_nxt;
    logic [2:0]         int_id_nxt;

    logic [15:0]        off;
    logic [3:0]         off_lo;
    logic               wr_ctrl;
    logic               wr_mask;
    logic               wr_pend;
    logic               wr_cur;
    logic               in_svc;
    logic               eoi;

    logic [N_SRC-1:0]   edge_det;
    logic [N_SRC-1:0]   eligible;
    logic [N_SRC-1:0]   id_onehot;
    logic               id_eligible;
    logic [2:0]         sel;
    logic               ack_take;
    logic [N_SRC-1:0]   clr;

    // Upper write-data and offset bits have no register behind them.
    logic               unused_bits;
    assign unused_bits = ^{wd, off[15:4]};

    // Only the low four bits of the offset select a register.
    assign off     = addr - BASE;
    assign off_lo  = off[3:0];
    assign wr_ctrl = we && (off_lo == OFF_CTRL);
    assign wr_mask = we && (off_lo == OFF_MASK);
    assign wr_pend = we && (off_lo == OFF_PEND);
    assign wr_cur  = we && (off_lo == OFF_CUR);

    // The in-service flag is exactly "FSM is in SERV".
    assign in_svc  = (state == SERV);
    assign eoi     = wr_cur && in_svc;

    assign edge_det = irq_in & ~irq_prev;
    assign eligible = ctrl_ge ? (pending & mask) : '0;

    // Lowest-index eligible source wins; index 0 has the highest priority.
    always_comb begin
        // NOTE: defaults first so every path assigns each output; no latch is inferred.
        sel = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) sel = 3'(i);
        end
    end

    // One-hot view of the current int_id, used for ack-clear and retract test.
    always_comb begin
        id_onehot = '0;
        for (int i = 0; i < N_SRC; i++) begin
            id_onehot[i] = (int_id == 3'(i));
        end
    end

    assign id_eligible = |(eligible & id_onehot);

    // Bits to clear this cycle: software W1C plus the source just acknowledged.
    assign clr = (wr_pend ? wd[N_SRC-1:0] : '0) | (ack_take ? id_onehot : '0);

    // Bus-visible configuration registers.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking (<=) for every register so all flops sample pre-edge values.
        if (reset) begin
            ctrl_ge <= 1'b0;
            mask    <= '0;
        end else begin
            if (wr_ctrl) ctrl_ge <= wd[0];
            if (wr_mask) mask    <= wd[N_SRC-1:0];
        end
    end

    // Edge capture and pending bits; a set in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending  <= '0;
            irq_prev <= irq_in;
        end else begin
            pending  <= (pending & ~clr) | edge_det;
            irq_prev <= irq_in;
        end
    end

    // Handshake FSM: state register together with the registered CPU outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            int_req <= 1'b0;
            int_id  <= '0;
        end else begin
            state   <= state_nxt;
            int_req <= int_req_nxt;
            int_id  <= int_id_nxt;
        end
    end

    // Handshake FSM: next state and next values of int_req / int_id.
    always_comb begin
        state_nxt   = state;
        int_req_nxt = int_req;
        int_id_nxt  = int_id;
        ack_take    = 1'b0;
        unique case (state)
            IDLE: begin
                int_req_nxt = 1'b0;
                if (|eligible) begin
                    int_id_nxt  = sel;
                    int_req_nxt = 1'b1;
                    state_nxt   = REQ;
                end
            end
            REQ: begin
                // An ack takes precedence over a simultaneous retract condition.
                if (int_ack) begin
                    ack_take    = 1'b1;
                    int_req_nxt = 1'b0;
                    state_nxt   = SERV;
                end else if (!id_eligible) begin
                    int_req_nxt = 1'b0;
                    state_nxt   = IDLE;
                end
            end
            SERV: begin
                int_req_nxt = 1'b0;
                if (eoi) state_nxt = IDLE;
            end
            default: begin
                int_req_nxt = 1'b0;
                state_nxt   = IDLE;
            end
        endcase
    end

    // Combinational read mux.
    always_comb begin
        rd = '0;
        unique case (off_lo)
            OFF_CTRL: rd = {31'b0, ctrl_ge};
            OFF_MASK: rd = {{(32-N_SRC){1'b0}}, mask};
            OFF_PEND: rd = {{(32-N_SRC){1'b0}}, pending};
            OFF_CUR:  rd = {in_svc, 28'b0, int_id};
            default:  rd = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed self-checking bench for irq_ctrl.
module tb_irq_ctrl;

    localparam logic [15:0] BASE  = 16'h7F20;
    localparam int          N_SRC = 6;
    localparam logic [15:0] A_CTRL = BASE + 16'h0;
    localparam logic [15:0] A_MASK = BASE + 16'h4;
    localparam logic [15:0] A_PEND = BASE + 16'h8;
    localparam logic [15:0] A_CUR  = BASE + 16'hC;

    logic             clk = 1'b0;
    logic             reset;
    logic [15:0]      addr;
    logic             we;
    logic [31:0]      wd;
    logic [31:0]      rd;
    logic [N_SRC-1:0] irq_in;
    logic             int_req;
    logic [2:0]       int_id;
    logic             int_ack;

    int errors = 0;
    int checks = 0;

    irq_ctrl #(.BASE(BASE), .N_SRC(N_SRC)) dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .we      (we),
        .wd      (wd),
        .rd      (rd),
        .irq_in  (irq_in),
        .int_req (int_req),
        .int_id  (int_id),
        .int_ack (int_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
        addr = a;
        wd   = d;
        we   = 1'b1;
        tick();
        we   = 1'b0;
        wd   = '0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
        addr = a;
        we   = 1'b0;
        #1;
        d = rd;
    endtask

    task automatic ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r;
        reset   = 1'b1;
        addr    = BASE;
        we      = 1'b0;
        wd      = '0;
        irq_in  = '0;
        int_ack = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_int_req", {31'b0, int_req}, 32'h0);
        check("rst_int_id", {29'b0, int_id}, 32'h0);
        bus_read(A_CUR, r);  check("rst_cur", r, 32'h0);
        bus_read(A_PEND, r); check("rst_pend", r, 32'h0);

        // Single source: edge on 2 -> request two cycles later
        bus_write(A_CTRL, 32'h1);
        bus_write(A_MASK, 32'h3F);
        bus_read(A_CTRL, r); check("ctrl_rb", r, 32'h1);
        bus_read(A_MASK, r); check("mask_rb", r, 32'h3F);
        irq_in = 6'b000100;
        tick();
        check("t1_req_cyc1", {31'b0, int_req}, 32'h0);
        tick();
        check("t1_req_cyc2", {31'b0, int_req}, 32'h1);
        check("t1_id", {29'b0, int_id}, 32'h2);
        bus_read(A_PEND, r); check("t1_pend", r, 32'h4);
        bus_read(A_CUR, r);  check("t1_cur_req", r, 32'h2);
        ack();
        check("t1_req_after_ack", {31'b0, int_req}, 32'h0);
        bus_read(A_CUR, r);  check("t1_cur_svc", r, 32'h8000_0002);
        bus_read(A_PEND, r); check("t1_pend_ack", r, 32'h0);
        irq_in = '0;
        bus_write(A_CUR, 32'h0);
        tick();
        check("t1_idle_no_req", {31'b0, int_req}, 32'h0);
        bus_read(A_CUR, r);  check("t1_cur_idle", r, 32'h2);

        // Two simultaneous edges: lowest index first, second after EOI
        irq_in = 6'b010010;
        tick();
        tick();
        check("t2_req", {31'b0, int_req}, 32'h1);
        check("t2_id", {29'b0, int_id}, 32'h1);
        ack();
        bus_read(A_CUR, r);  check("t2_cur_svc", r, 32'h8000_0001);
        tick();
        check("t2_serv_blocks", {31'b0, int_req}, 32'h0);
        irq_in = '0;
        bus_write(A_CUR, 32'h0);
        check("t2_eoi_cyc1", {31'b0, int_req}, 32'h0);
        tick();
        check("t2_eoi_cyc2_req", {31'b0, int_req}, 32'h1);
        check("t2_eoi_cyc2_id", {29'b0, int_id}, 32'h4);
        ack();
        bus_write(A_CUR, 32'h0);

        // Masked source stays pending until unmasked
        bus_write(A_MASK, 32'h37);
        irq_in = 6'b001000;
        repeat (3) tick();
        check("t3_masked_req", {31'b0, int_req}, 32'h0);
        bus_read(A_PEND, r); check("t3_pend", r, 32'h8);
        bus_write(A_MASK, 32'h3F);
        check("t3_unmask_cyc1", {31'b0, int_req}, 32'h0);
        tick();
        check("t3_unmask_req", {31'b0, int_req}, 32'h1);
        check("t3_unmask_id", {29'b0, int_id}, 32'h3);
        ack();
        irq_in = '0;
        bus_write(A_CUR, 32'h0);

        // Retract: W1C of the requested source before ack
        irq_in = 6'b000001;
        tick();
        tick();
        check("t4_req", {31'b0, int_req}, 32'h1);
        check("t4_id", {29'b0, int_id}, 32'h0);
        bus_write(A_PEND, 32'h1);
        check("t4_req_still", {31'b0, int_req}, 32'h1);
        tick();
        check("t4_retract", {31'b0, int_req}, 32'h0);
        bus_read(A_PEND, r); check("t4_pend", r, 32'h0);
        ack();
        bus_read(A_CUR, r);  check("t4_ack_in_idle", r, 32'h0);
        tick();
        check("t4_stay_idle", {31'b0, int_req}, 32'h0);

        // SERV: new edges accumulate, no request; set beats simultaneous clear
        irq_in = 6'b000011;
        tick();
        tick();
        check("t5_req_id", {29'b0, int_id}, 32'h1);
        ack();
        irq_in = 6'b100011;
        tick();
        tick();
        check("t5_serv_no_req", {31'b0, int_req}, 32'h0);
        bus_read(A_PEND, r); check("t5_pend_set", r, 32'h20);
        irq_in = 6'b000011;
        bus_write(A_PEND, 32'h20);
        bus_read(A_PEND, r); check("t5_w1c", r, 32'h0);
        irq_in = 6'b100011;
        bus_write(A_PEND, 32'h20);
        bus_read(A_PEND, r); check("t5_set_wins", r, 32'h20);
        check("t5_serv_still", {31'b0, int_req}, 32'h0);
        bus_read(A_CUR, r);  check("t5_cur_svc", r, 32'h8000_0001);

        // Reset while in SERV, with lines 0/1/5 held high throughout
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("t6_int_req", {31'b0, int_req}, 32'h0);
        bus_read(A_CUR, r);  check("t6_cur", r, 32'h0);
        bus_read(A_CTRL, r); check("t6_ctrl", r, 32'h0);
        bus_read(A_MASK, r); check("t6_mask", r, 32'h0);
        tick();
        tick();
        bus_read(A_PEND, r); check("t6_no_pend", r, 32'h0);

        // Global-enable retract, and EOI outside SERV ignored
        bus_write(A_MASK, 32'h3F);
        bus_write(A_CTRL, 32'h1);
        irq_in = 6'b100111;
        tick();
        tick();
        check("t7_req_id", {29'b0, int_id}, 32'h2);
        bus_write(A_CTRL, 32'h0);
        tick();
        check("t7_ge_retract", {31'b0, int_req}, 32'h0);
        bus_read(A_PEND, r); check("t7_pend_kept", r, 32'h4);
        bus_write(A_CTRL, 32'h1);
        tick();
        check("t7_rereq", {31'b0, int_req}, 32'h1);
        bus_write(A_CUR, 32'h0);
        tick();
        check("t7_eoi_in_req", {31'b0, int_req}, 32'h1);
        bus_read(A_CUR, r);  check("t7_cur_req", r, 32'h2);
        bus_read(BASE + 16'h2, r); check("t7_bad_off", r, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Memory-mapped interrupt controller on the CPU side of the device IRQ lines, e.g. the timer IRQ.
- Captures rising edges on up to 8 device request lines into pending bits and applies a per-source mask and a global enable.
- Presents one prioritised request to the CPU with a req/ack handshake, then blocks further requests until software writes end-of-interrupt.
- Sits on the same device bus as the timers: 16-bit byte address, word write data, combinational read data.

Parameters:
BASE, 16'h7F20, byte address of register offset 0x0
N_SRC, 6, number of interrupt source lines, 1..8

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high reset
addr  input  16  bus byte address
we  input  1  bus write enable
wd  input  32  bus write data
rd  output  32  bus read data, combinational
irq_in  input  N_SRC  device request lines, level, synchronous to clk
int_req  output  1  request to CPU, registered
int_id  output  3  index of the requested/in-service source, registered
int_ack  input  1  CPU accepts request, one-cycle pulse

Behaviour:
- Reset is synchronous, active-high, on clk. Reset cycle:
  - ctrl, mask, pending, int_req, int_id = 0; FSM = IDLE.
  - irq_prev <= irq_in, so a line already high at reset makes no edge.
- Register select: off = addr - BASE, low 4 bits.
  - Offset 0x0 CTRL: bit0 = GE (global enable); other bits read 0.
  - Offset 0x4 MASK: bits [N_SRC-1:0] = 1 enables that source.
  - Offset 0x8 PEND: read returns pending. A write clears every pending bit whose wd bit is 1 (write-1-to-clear).
  - Offset 0xC CUR: read returns {in_svc, 28'b0, int_id}. Any write is EOI.
  - Any other offset reads 0; writes there are ignored.
- Edge capture, every cycle: edge = irq_in & ~irq_prev; irq_prev <= irq_in.
- Pending update: pending <= (pending & ~clr) | edge.
  - clr = PEND W1C bits, plus the acked source bit on int_ack.
  - If a source's edge and its clear land in the same cycle, set wins; no event is lost.
- eligible = pending & mask, gated by GE. sel = lowest-index set bit of eligible; index 0 is highest priority.
- Bus writes and FSM advance in the same cycle; the bus does not stall the FSM. Register writes affect the FSM from the next cycle.
- FSM states: IDLE, REQ, SERV.
  - IDLE: if eligible != 0, then int_id <= sel, int_req <= 1, go REQ.
  - REQ, int_ack = 1: clear pending[int_id], int_req <= 0, in_svc <= 1, go SERV.
  - REQ, ack absent and source no longer eligible (GE cleared, mask bit cleared or pending bit cleared by W1C): int_req <= 0, go IDLE (retract).
  - REQ: int_id does not change while in REQ; a higher-priority edge arriving during REQ does not preempt.
  - SERV: int_req stays 0; new edges still accumulate in pending. An EOI write sets in_svc <= 0 and goes IDLE.
  - SERV, next cycle in IDLE: if eligible is nonzero, the request is re-raised with the standard one-cycle IDLE->REQ latency.
- Handshake error cases:
  - int_ack outside REQ is ignored.
  - EOI outside SERV is ignored.
  - Ack and retract condition in the same cycle: ack wins.
- Latency: edge on irq_in at cycle t -> pending at t+1 -> int_req high at t+2, when idle, enabled and unmasked.
- int_id keeps its last value in IDLE. Bits of int_id at or above N_SRC never become 1.

Test Plan:
- Reset then CTRL=1, MASK=0x3F, pulse irq_in[2] -> int_req=1 and int_id=2 exactly 2 cycles later; PEND reads 0x4.
- irq_in[4] and irq_in[1] rise together -> int_id=1; ack -> CUR reads 0x80000001; EOI -> int_id=4 requested 2 cycles later.
- irq_in[3] rises with MASK=0x37 -> pending bit 3 set, int_req stays 0; write MASK=0x3F -> int_req=1 with int_id=3.
- In REQ for id 0, write PEND=0x1 before ack -> int_req drops next cycle, FSM back in IDLE, PEND reads 0.
- In SERV, edge on irq_in[5] -> no int_req until EOI; W1C of bit 5 in the same cycle as a new edge on 5 -> PEND bit 5 stays 1.
- irq_in[0] held high through reset -> no pending after reset; assert reset while in SERV -> int_req=0, CUR reads 0, CTRL and MASK read 0.
